// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: raw (active-high) segment
// patterns and segment bit positions.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Entry n is the glyph for nibble n (0-9, A, b, C, d, E, F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to raw 7-segment pattern. In decimal mode, nibbles above 9 render
// as a dash so out-of-range data is visibly flagged.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_TABLE[nibble];
    if (!hex_mode && (nibble > 4'd9)) begin
      pattern = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: shadow/display double buffer swapped at
// frame wrap, with segments, dp and digit enable registered together.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 1000,
  parameter int ACTIVE_LOW  = 0,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    lz_en,
  input  logic                    blank,
  output logic [6:0]              segments,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0]        slot_cnt_reg, slot_cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_val_reg, disp_val_reg, disp_val_next;
  logic [NUM_DIGITS-1:0]   shadow_dp_reg, disp_dp_reg, disp_dp_next;
  logic                    pending_reg, frame_done_reg, frame_done_next;
  logic [NUM_DIGITS-1:0]   digit_en_reg, digit_en_next;
  logic [6:0]              seg_reg, seg_next, raw_pat;
  logic                    dp_reg, dp_next;
  logic                    slot_end, wrap, transfer, lz_hit;
  logic [3:0]              nib [NUM_DIGITS];
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS:0]     zero_from;

  assign slot_end      = (slot_cnt_reg == LAST_SLOT);
  assign wrap          = slot_end && (idx_reg == LAST_IDX);
  assign transfer      = wrap && pending_reg;
  assign slot_cnt_next = slot_end ? '0 : slot_cnt_reg + 1'b1;
  assign idx_next      = !slot_end ? idx_reg : (wrap ? '0 : idx_reg + 1'b1);
  assign disp_val_next = transfer ? shadow_val_reg : disp_val_reg;
  assign disp_dp_next  = transfer ? shadow_dp_reg : disp_dp_reg;

  // Outputs are computed from next-state so the glyph, dp and enable
  // all switch on the same edge as the digit index.
  assign zero_from[NUM_DIGITS] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]           = disp_val_next[4*gi +: 4];
      assign zero_from[gi]     = (nib[gi] == 4'd0) && zero_from[gi+1];
      assign digit_en_next[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  assign cur_nib = nib[idx_next];

  seg7_decode u_decode (
    .nibble   (cur_nib),
    .hex_mode (hex_mode),
    .pattern  (raw_pat)
  );

  assign lz_hit = (LZ_BLANK != 0) && lz_en && (idx_next != '0) && zero_from[idx_next];
  assign seg_next = (blank || lz_hit) ? SEG_OFF : raw_pat;
  assign dp_next  = !blank && disp_dp_next[idx_next];
  assign frame_done_next = (slot_cnt_next == LAST_SLOT) && (idx_next == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt_reg   <= '0;
      idx_reg        <= '0;
      shadow_val_reg <= '0;
      shadow_dp_reg  <= '0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      digit_en_reg   <= NUM_DIGITS'(1);
      seg_reg        <= SEG_TABLE[0];
      dp_reg         <= 1'b0;
    end else begin
      slot_cnt_reg   <= slot_cnt_next;
      idx_reg        <= idx_next;
      disp_val_reg   <= disp_val_next;
      disp_dp_reg    <= disp_dp_next;
      frame_done_reg <= frame_done_next;
      digit_en_reg   <= digit_en_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      if (load) begin
        shadow_val_reg <= value;
        shadow_dp_reg  <= dp;
        pending_reg    <= 1'b1;
      end else if (transfer) begin
        pending_reg    <= 1'b0;
      end
    end
  end

  assign segments   = seg_reg ^ {7{ACTIVE_LOW != 0}};
  assign dp_out     = dp_reg ^ (ACTIVE_LOW != 0);
  assign digit_en   = digit_en_reg ^ {NUM_DIGITS{ACTIVE_LOW != 0}};
  assign frame_done = frame_done_reg;
  assign pending    = pending_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan timing, double buffering,
// decode, blanking, active-low polarity and asynchronous reset.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load, hex_mode, lz_en, blank, blank_al;
  logic [6:0]  segments, segments_al;
  logic        dp_out, dp_out_al, frame_done, frame_done_al, pending, pending_al;
  logic [3:0]  digit_en, digit_en_al;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(4), .ACTIVE_LOW(0), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .hex_mode(hex_mode), .lz_en(lz_en), .blank(blank),
    .segments(segments), .dp_out(dp_out), .digit_en(digit_en),
    .frame_done(frame_done), .pending(pending)
  );

  seg7_scan_driver #(.NUM_DIGITS(4), .SLOT_CYCLES(4), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut_al (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load),
    .hex_mode(hex_mode), .lz_en(lz_en), .blank(blank_al),
    .segments(segments_al), .dp_out(dp_out_al), .digit_en(digit_en_al),
    .frame_done(frame_done_al), .pending(pending_al)
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the last cycle of a frame (frame_done high).
  task automatic wait_fd();
    int k;
    for (k = 0; k < 40; k++) begin
      step();
      if (frame_done) break;
    end
    if (k == 40) chk_vec("fd_timeout", 32'd0, 32'd1);
  endtask

  // Starts in a wrap cycle; samples each digit slot and ends in the next wrap cycle.
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (c == 0) begin
          cap_seg[d] = segments;
          cap_dp[d]  = dp_out;
          chk_vec($sformatf("cap_en%0d", d), 32'(digit_en), 32'(4'b0001 << d));
        end
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    step();
    value = v;
    dp    = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
    chk_vec({tag, "_d0"}, 32'(cap_seg[0]), 32'(s0));
    chk_vec({tag, "_d1"}, 32'(cap_seg[1]), 32'(s1));
    chk_vec({tag, "_d2"}, 32'(cap_seg[2]), 32'(s2));
    chk_vec({tag, "_d3"}, 32'(cap_seg[3]), 32'(s3));
  endtask

  initial begin
    reset = 1'b1; value = '0; dp = '0; load = 1'b0;
    hex_mode = 1'b1; lz_en = 1'b0; blank = 1'b0; blank_al = 1'b1;
    #1;
    chk_vec("rst_en", 32'(digit_en), 32'h1);
    chk_vec("rst_seg", 32'(segments), 32'h3F);
    chk_vec("rst_dp", 32'(dp_out), 32'h0);
    chk_vec("rst_pend", 32'(pending), 32'h0);
    chk_vec("rst_fd", 32'(frame_done), 32'h0);
    chk_vec("rst_al_en", 32'(digit_en_al), 32'hE);
    chk_vec("rst_al_seg", 32'(segments_al), 32'h40);
    #11 reset = 1'b0;

    // Scan order, frame_done cadence and active-low blanked instance.
    for (int n = 1; n <= 20; n++) begin
      step();
      chk_vec($sformatf("scan_en_%0d", n), 32'(digit_en), 32'(4'b0001 << ((n / 4) % 4)));
      chk_vec($sformatf("scan_fd_%0d", n), 32'(frame_done), 32'((n % 16) == 15));
      chk_vec($sformatf("al_en_%0d", n), 32'(digit_en_al), 32'(~(4'b0001 << ((n / 4) % 4)) & 4'hF));
      if (n % 4 == 1) begin
        chk_vec($sformatf("al_seg_%0d", n), 32'(segments_al), 32'h7F);
        chk_vec($sformatf("al_dp_%0d", n), 32'(dp_out_al), 32'h1);
      end
    end

    // Mid-frame load is held until the wrap.
    value = 16'h12AF; dp = 4'b0000; hex_mode = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    chk_vec("ld_pend", 32'(pending), 32'h1);
    chk_vec("ld_hold_seg", 32'(segments), 32'h3F);
    wait_fd();
    chk_vec("ld_pend_wrap", 32'(pending), 32'h1);
    capture_frame();
    chk_frame("hex12AF", 7'h71, 7'h77, 7'h5B, 7'h06);
    chk_vec("ld_pend_clr", 32'(pending), 32'h0);

    // Decimal mode dash and leading-zero blanking.
    hex_mode = 1'b0; lz_en = 1'b1;
    do_load(16'h00C5, 4'b0000);
    wait_fd();
    capture_frame();
    chk_frame("lz_on", 7'h6D, 7'h40, 7'h00, 7'h00);
    lz_en = 1'b0;
    capture_frame();
    chk_frame("lz_off", 7'h6D, 7'h40, 7'h3F, 7'h3F);

    // All-zero word keeps digit 0; dp of a blanked digit still shows.
    lz_en = 1'b1;
    do_load(16'h0000, 4'b0100);
    wait_fd();
    capture_frame();
    chk_frame("zero", 7'h3F, 7'h00, 7'h00, 7'h00);
    for (int d = 0; d < 4; d++)
      chk_vec($sformatf("zero_dp%0d", d), 32'(cap_dp[d]), 32'(d == 2));

    // Load coinciding with the wrap, then overwritten two clocks later.
    hex_mode = 1'b1; lz_en = 1'b0;
    do_load(16'h0789, 4'b0000);
    wait_fd();
    value = 16'h0BCD; load = 1'b1;
    step();
    load = 1'b0;
    chk_vec("wrapld_pend", 32'(pending), 32'h1);
    chk_vec("wrapld_en", 32'(digit_en), 32'h1);
    chk_vec("wrapld_seg", 32'(segments), 32'h6F);
    step();
    value = 16'hDEF0; load = 1'b1;
    step();
    load = 1'b0;
    chk_vec("lastwin_pend", 32'(pending), 32'h1);
    wait_fd();
    capture_frame();
    chk_frame("lastwin", 7'h3F, 7'h71, 7'h79, 7'h5E);
    chk_vec("lastwin_pend_clr", 32'(pending), 32'h0);

    // blank overrides decode while scanning continues.
    blank = 1'b1;
    step();
    chk_vec("blank_seg", 32'(segments), 32'h0);
    chk_vec("blank_dp", 32'(dp_out), 32'h0);
    chk_vec("blank_en", 32'(digit_en), 32'h1);
    blank = 1'b0;

    // Asynchronous reset mid-slot discards the pending shadow.
    do_load(16'h8888, 4'b1111);
    step(); step(); step();
    chk_vec("pre_rst_pend", 32'(pending), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk_vec("arst_en", 32'(digit_en), 32'h1);
    chk_vec("arst_seg", 32'(segments), 32'h3F);
    chk_vec("arst_dp", 32'(dp_out), 32'h0);
    chk_vec("arst_pend", 32'(pending), 32'h0);
    chk_vec("arst_al_en", 32'(digit_en_al), 32'hE);
    #3 reset = 1'b0;
    wait_fd();
    capture_frame();
    chk_frame("post_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    chk_vec("post_rst_pend", 32'(pending), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
